// File: rtl/ring_pkg.sv
// ring_pkg: VC identifiers, packet field positions and the hop-shift helper shared by the ring input buffer.
package ring_pkg;

    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    localparam int PKT_W       = 64;
    localparam int PKT_VC_BIT  = PKT_W - 1;
    localparam int PKT_HOP_LSB = 48;
    localparam int PKT_HOP_W   = 8;

    // Shifts the hop field [lsb+w-1:lsb] right by one (zero fill); all other bits pass through.
    function automatic logic [PKT_W-1:0] hop_shift(input logic [PKT_W-1:0] p, input int lsb, input int w);
        logic [PKT_W-1:0] r;
        r = p;
        for (int i = 0; i < PKT_W; i++)
            if (i >= lsb && i < lsb + w)
                r[i] = (i + 1 < lsb + w) ? p[i+1] : 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/ring_vc_input_buffer_vc_slot.sv
// vc_slot: one-entry packet register with full flag.
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en_i      load data_i and set full
//   rd_en_i      clear full (data is left stale)
//   data_i       packet to store
//   full_o       entry occupied
//   data_o       stored packet
module vc_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_i,
    input  logic         rd_en_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= wr_en_i ? 1'b1 : (rd_en_i ? 1'b0 : full_q);
            data_q <= wr_en_i ? data_i : data_q;
        end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/ring_vc_input_buffer.sv
// ring_vc_input_buffer: router input port with two single-entry VCs swapped by global polarity.
//   clk, reset        clock, asynchronous active-low reset
//   polarity          1: external VC is VC0, internal VC1; 0: the reverse
//   in_si/in_ri/in_di upstream strobe, ready, packet (bit DATA_W-1 selects the VC)
//   out_so/out_ro/out_do downstream strobe, ready, packet with hop field shifted right
//   vc_full           occupancy per VC
//   vc_err            one-cycle pulse after a packet dropped for VC mismatch
//   drop_cnt          saturating dropped-packet count
module ring_vc_input_buffer
    import ring_pkg::*;
#(
    parameter int DATA_W  = PKT_W,
    parameter int HOP_LSB = PKT_HOP_LSB,
    parameter int HOP_W   = PKT_HOP_W,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              in_si,
    output logic              in_ri,
    input  logic [DATA_W-1:0] in_di,
    output logic              out_so,
    input  logic              out_ro,
    output logic [DATA_W-1:0] out_do,
    output logic [1:0]        vc_full,
    output logic              vc_err,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic              ext_vc, int_vc, acc, match, wr;
    logic [1:0]        wr_en, rd_en;
    logic [DATA_W-1:0] slot_data [2];
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign ext_vc = ~polarity;
    assign int_vc = polarity;
    assign in_ri  = ~vc_full[ext_vc];
    assign acc    = in_si & in_ri;
    assign match  = in_di[DATA_W-1] == ext_vc;
    assign wr     = acc & match;
    assign out_so = vc_full[int_vc] & out_ro;

    // ext_vc and int_vc always differ, so a slot is never written and read together.
    assign wr_en = {wr & (ext_vc == VC_ODD), wr & (ext_vc == VC_EVEN)};
    assign rd_en = {out_so & (int_vc == VC_ODD), out_so & (int_vc == VC_EVEN)};

    genvar v;
    generate
        for (v = 0; v < 2; v++) begin : g_slot
            vc_slot #(.W(DATA_W)) u_slot (
                .clk     (clk),
                .rst_n   (reset),
                .wr_en_i (wr_en[v]),
                .rd_en_i (rd_en[v]),
                .data_i  (in_di),
                .full_o  (vc_full[v]),
                .data_o  (slot_data[v])
            );
        end
    endgenerate

    assign out_do = out_so ? DATA_W'(hop_shift(PKT_W'(slot_data[int_vc]), HOP_LSB, HOP_W)) : '0;

    always_comb begin
        err_d = acc & ~match;
        cnt_d = (err_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end

    assign vc_err   = err_q;
    assign drop_cnt = cnt_q;

endmodule

// File: doc/ring_vc_input_buffer.md
Name: ring_vc_input_buffer

Overview:
- Router input port that sits directly downstream of the NIC.
- Consumes the NIC's network-side output (net_so/net_ro/net_do) into two single-entry virtual-channel buffers, even (VC0) and odd (VC1).
- Forwards each stored packet on the internal VC toward the router crossbar/output stage.
- The global polarity selects which VC faces external traffic and which is internal in any cycle; the two VCs swap every time polarity toggles.

Parameters:
- DATA_W, 64, packet width; bit DATA_W-1 is the VC bit.
- HOP_LSB, 48, LSB of the hop field inside the packet.
- HOP_W, 8, width of the hop field.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low: reset==0 immediately clears all state
- polarity  in  1  global polarity; 1 = external VC is even (VC0), internal VC is odd (VC1); 0 = the reverse
- in_si  in  1  upstream (NIC) send strobe
- in_ri  out  1  ready to upstream
- in_di  in  DATA_W  upstream packet
- out_so  out  1  send strobe to downstream stage
- out_ro  in  1  downstream ready
- out_do  out  DATA_W  forwarded packet
- vc_full  out  2  occupancy flags; [0]=VC0, [1]=VC1
- vc_err  out  1  one-cycle pulse on a dropped, mismatched packet
- drop_cnt  out  CNT_W  saturating count of dropped packets

Behaviour:
- Definitions: ext_vc = ~polarity; int_vc = polarity.
- Reset (reset==0, asynchronous):
  - both buffers empty, vc_full=2'b00
  - buffer contents = 0
  - vc_err=0, drop_cnt=0
  - in_ri follows its combinational definition, so it reads 1 while in reset
  - out_so=0, out_do=0
- Upstream side:
  - in_ri = ~vc_full[ext_vc], combinational from state and polarity.
  - Accept at a rising edge when in_si & in_ri.
  - If in_di[DATA_W-1]==ext_vc: store in_di in buffer ext_vc and set vc_full[ext_vc].
  - Otherwise drop the packet: buffer unchanged, vc_err=1 for the following cycle, drop_cnt += 1 (saturates at all-ones).
  - in_si while in_ri==0 is ignored; no state change and no error.
- Downstream side:
  - out_so = vc_full[int_vc] & out_ro, combinational.
  - out_do = buffer[int_vc] with the hop field [HOP_LSB+HOP_W-1:HOP_LSB] shifted right by 1 (zero fill), when out_so=1; otherwise out_do=0.
  - On an edge with out_so=1, clear vc_full[int_vc]. The buffer data may stay stale.
- Simultaneous events:
  - A write to ext_vc and a read from int_vc in the same cycle touch different buffers, so both complete.
  - A buffer can never be read and written in one cycle.
- Latency: a packet accepted at edge N under polarity p is forwardable from the first cycle in which polarity==~p, i.e. minimum 1 cycle when polarity toggles every cycle.
- Polarity held constant: the external buffer fills once and in_ri drops until polarity flips and the packet drains.
- Reset mid-operation: any held packets are lost. vc_err clears; no partial output.
- vc_err is registered; it never asserts in the same cycle as the offending in_si.
- Stored packet contents are otherwise unmodified; the hop shift applies only on output.

Decomposition:
- Shared package ring_pkg holds:
  - VC_EVEN=1'b0, VC_ODD=1'b1
  - packet field positions (VC bit, HOP_LSB, HOP_W)
  - a hop-shift helper function
- Natural sub-module: vc_slot, one instance per VC. Each is a one-entry register plus full flag with wr_en/rd_en/data ports. The top module holds polarity muxing, error logic and the counter.

Test Plan:
1. Reset, then polarity=1, in_si=1, in_di=64'h0000_0000_0000_04D2 (VC bit 0) -> in_ri=1 before the edge; after the edge vc_full=2'b01, in_ri=0, out_so=0.
2. Next cycle polarity=0, out_ro=1 -> out_so=1, out_do=64'h0000_0000_0000_04D2 with hop field unchanged (0). After the edge vc_full=2'b00.
3. Hop shift: store 64'h0080_0000_0000_0001 on VC0, toggle polarity, out_ro=1 -> out_do=64'h0040_0000_0000_0001.
4. Concurrency, polarity toggling every cycle:
   - Packet A = 64'h0 accepted under polarity=1 (stored on VC0).
   - Next cycle, polarity=0, out_ro=1, in_di=64'h8000_0000_0000_0001: A forwarded and B stored on VC1 in the same cycle.
   - After the edge vc_full=2'b10.
5. Mismatch: polarity=1, in_di=64'h8000_0000_0000_0005 (VC bit 1), in_si=1 -> vc_full unchanged, vc_err=1 for exactly one cycle, drop_cnt=1. Repeat 256 times -> drop_cnt saturates at 8'hFF.
6. Backpressure and reset:
   - Both VCs full and out_ro=0 -> out_so=0, in_ri=0, in_si ignored.
   - Pull reset low asynchronously mid-cycle -> vc_full=2'b00, out_so=0 immediately, without waiting for a clock edge.
